// File: rtl/wb_trace_buffer_if.sv
// Trace read port between wb_trace_buffer and its consumer.
// Ports:
//   rdValid - head entry present (driven by buffer)
//   rdReady - consumer accepts the head entry this cycle
//   rdStamp - head entry cycle stamp
//   rdDest  - head entry destination register
//   rdData  - head entry register data
interface wb_trace_buffer_if #(
    parameter int DATA_W  = 32,
    parameter int CYCLE_W = 16
);
    logic               rdValid;
    logic               rdReady;
    logic [CYCLE_W-1:0] rdStamp;
    logic [4:0]         rdDest;
    logic [DATA_W-1:0]  rdData;

    modport master (output rdValid, rdStamp, rdDest, rdData, input rdReady);
    modport slave  (input rdValid, rdStamp, rdDest, rdData, output rdReady);
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback-stage trace capture. Taps WB register writes of the pipeline and
// records {cycle stamp, dest, data} into a first-word-fall-through FIFO that
// is drained over the rd interface.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   pc, trigPc        - fetch PC and trigger PC compared while ARMED
//   wwreg, wm2reg     - WB write enable, WB data select (1 = wdo, 0 = wr)
//   wdestReg, wr, wdo - WB destination, ALU result, memory data
//   arm, stop, trigEn - capture control
//   rd                - trace read port (valid/ready)
//   state, full       - FSM state (0 IDLE,1 ARMED,2 CAPTURE,3 DONE), FIFO full
//   commitCnt, ovfCnt - saturating commit and lost-entry counters
module wb_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int CYCLE_W   = 16,
    parameter int CNT_W     = 16,
    parameter int WRAP_MODE = 0,
    parameter int SKIP_R0   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic                wwreg,
    input  logic                wm2reg,
    input  logic [4:0]          wdestReg,
    input  logic [DATA_W-1:0]   wr,
    input  logic [DATA_W-1:0]   wdo,
    input  logic                arm,
    input  logic                stop,
    input  logic                trigEn,
    input  logic [31:0]         trigPc,
    wb_trace_buffer_if.master   rd,
    output logic [1:0]          state,
    output logic                full,
    output logic [CNT_W-1:0]    commitCnt,
    output logic [CNT_W-1:0]    ovfCnt
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = CYCLE_W + 5 + DATA_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CYCLE_W-1:0]   cyc_q;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic [CNT_W-1:0]     commit_q, ovf_q;

    logic                 arm_ok, wr_ev, cap, pop, is_full;
    logic                 push_ok, overflow, wrap_adv;
    logic [DATA_W-1:0]    wdata;
    logic [ENTRY_W-1:0]   head;

    assign wdata   = wm2reg ? wdo : wr;
    assign wr_ev   = wwreg && !((SKIP_R0 != 0) && (wdestReg == 5'd0));
    assign cap     = (state_q == S_CAPTURE) && wr_ev;
    assign is_full = (count_q == FULL_CNT);
    assign pop     = rd.rdReady && (count_q != '0);

    // Stop overrides everything, including an arm in the same cycle.
    always_comb begin
        state_d = state_q;
        arm_ok  = 1'b0;
        if (stop) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (arm) begin
                    state_d = S_ARMED;
                    arm_ok  = 1'b1;
                end
                S_ARMED:   if (!trigEn || (pc == trigPc)) state_d = S_CAPTURE;
                S_CAPTURE: if ((WRAP_MODE == 0) && is_full) state_d = S_DONE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Full without a pop: stop mode drops the write; wrap mode overwrites
    // the head slot (wr_ptr == rd_ptr) and advances both pointers.
    always_comb begin
        push_ok  = 1'b0;
        overflow = 1'b0;
        wrap_adv = 1'b0;
        if (cap) begin
            if (!is_full || pop) begin
                push_ok = 1'b1;
            end else begin
                overflow = 1'b1;
                if (WRAP_MODE != 0) begin
                    push_ok  = 1'b1;
                    wrap_adv = 1'b1;
                end
            end
        end
        count_d = count_q;
        if (push_ok && !wrap_adv) count_d = count_d + 1'b1;
        if (pop)                  count_d = count_d - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            commit_q <= '0;
            ovf_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_q + 1'b1;
            if (arm_ok) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                commit_q <= '0;
                ovf_q    <= '0;
            end else begin
                count_q <= count_d;
                if (push_ok)          wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop || wrap_adv)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (cap && (commit_q != '1))      commit_q <= commit_q + 1'b1;
                if (overflow && (ovf_q != '1))    ovf_q    <= ovf_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !arm_ok && push_ok) mem[wr_ptr_q] <= {cyc_q, wdestReg, wdata};
    end

    assign head       = mem[rd_ptr_q];
    assign rd.rdValid = (count_q != '0);
    assign rd.rdStamp = rd.rdValid ? head[ENTRY_W-1 -: CYCLE_W] : '0;
    assign rd.rdDest  = rd.rdValid ? head[DATA_W +: 5]          : '0;
    assign rd.rdData  = rd.rdValid ? head[DATA_W-1:0]           : '0;

    assign state     = state_q;
    assign full      = is_full;
    assign commitCnt = commit_q;
    assign ovfCnt    = ovf_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: two DEPTH=4 instances (index 0 stop-on-full,
// index 1 wrap) share stimulus and are checked against a queue-based model.
module tb_wb_trace_buffer;
    logic        clk = 1'b0;
    logic        rst, wwreg, wm2reg, arm, stop, trig_en, rd_ready;
    logic [4:0]  wdest;
    logic [31:0] pc, trig_pc, wr, wdo;

    always #5 clk = ~clk;

    wb_trace_buffer_if #(.DATA_W(32), .CYCLE_W(16)) if0 ();
    wb_trace_buffer_if #(.DATA_W(32), .CYCLE_W(16)) if1 ();
    assign if0.rdReady = rd_ready;
    assign if1.rdReady = rd_ready;

    logic [1:0]  st0, st1;
    logic        fl0, fl1;
    logic [15:0] cc0, cc1, oc0, oc1;

    wb_trace_buffer #(.DEPTH(4), .WRAP_MODE(0)) u0 (
        .clk(clk), .rst(rst), .pc(pc), .wwreg(wwreg), .wm2reg(wm2reg),
        .wdestReg(wdest), .wr(wr), .wdo(wdo), .arm(arm), .stop(stop),
        .trigEn(trig_en), .trigPc(trig_pc), .rd(if0), .state(st0),
        .full(fl0), .commitCnt(cc0), .ovfCnt(oc0)
    );
    wb_trace_buffer #(.DEPTH(4), .WRAP_MODE(1)) u1 (
        .clk(clk), .rst(rst), .pc(pc), .wwreg(wwreg), .wm2reg(wm2reg),
        .wdestReg(wdest), .wr(wr), .wdo(wdo), .arm(arm), .stop(stop),
        .trigEn(trig_en), .trigPc(trig_pc), .rd(if1), .state(st1),
        .full(fl1), .commitCnt(cc1), .ovfCnt(oc1)
    );

    logic [1:0]  st [2];
    logic        fl [2], rv [2];
    logic [15:0] cc [2], oc [2], rs [2];
    logic [4:0]  rdst [2];
    logic [31:0] rdat [2];
    assign st[0] = st0;  assign st[1] = st1;
    assign fl[0] = fl0;  assign fl[1] = fl1;
    assign cc[0] = cc0;  assign cc[1] = cc1;
    assign oc[0] = oc0;  assign oc[1] = oc1;
    assign rv[0] = if0.rdValid;  assign rv[1] = if1.rdValid;
    assign rs[0] = if0.rdStamp;  assign rs[1] = if1.rdStamp;
    assign rdst[0] = if0.rdDest; assign rdst[1] = if1.rdDest;
    assign rdat[0] = if0.rdData; assign rdat[1] = if1.rdData;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned stamp;
        int unsigned dest;
        logic [31:0] data;
    } ent_t;

    localparam int MDEPTH = 4;
    localparam int CMAX   = 65535;

    ent_t        mq [2][$];
    int          m_state  [2] = '{0, 0};
    int          m_commit [2] = '{0, 0};
    int          m_ovf    [2] = '{0, 0};
    int unsigned m_cyc = 0;

    task automatic model_edge(input int k);
        int   n, nst;
        bit   pop, ev, cap, arm_ok;
        ent_t e;
        if (rst) begin
            mq[k].delete();
            m_state[k] = 0; m_commit[k] = 0; m_ovf[k] = 0;
            return;
        end
        n      = mq[k].size();
        pop    = rd_ready && (n != 0);
        ev     = wwreg && (wdest != 5'd0);
        cap    = ev && (m_state[k] == 2);
        arm_ok = arm && !stop && (m_state[k] == 0 || m_state[k] == 3);
        nst    = m_state[k];
        if (stop)                                         nst = 3;
        else if (arm_ok)                                  nst = 1;
        else if (m_state[k] == 1 && (!trig_en || pc == trig_pc)) nst = 2;
        else if (m_state[k] == 2 && k == 0 && n == MDEPTH) nst = 3;
        if (arm_ok) begin
            mq[k].delete();
            m_commit[k] = 0; m_ovf[k] = 0;
        end else begin
            if (cap && m_commit[k] < CMAX) m_commit[k]++;
            if (pop) void'(mq[k].pop_front());
            if (cap) begin
                e.stamp = m_cyc; e.dest = wdest; e.data = wm2reg ? wdo : wr;
                if (n == MDEPTH && !pop) begin
                    if (m_ovf[k] < CMAX) m_ovf[k]++;
                    if (k == 1) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(e);
                    end
                end else begin
                    mq[k].push_back(e);
                end
            end
        end
        m_state[k] = nst;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_edge(k);
        m_cyc = rst ? 0 : (m_cyc + 1) % 65536;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; wwreg = 0; wm2reg = 0; arm = 0; stop = 0; rd_ready = 0;
        wdest = 0; wr = 0; wdo = 0;
    endtask

    task automatic do_write(input logic [4:0] d, input logic [31:0] v);
        wwreg = 1; wm2reg = 0; wdest = d; wr = v;
        step();
        wwreg = 0;
    endtask

    task automatic pulse_arm();
        arm = 1; step(); arm = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; step(); stop = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs(); trig_en = 0; trig_pc = 0; pc = 0;
        rst = 1; step(); step(); rst = 0;
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (st[k] !== 2'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d want 0", k, st[k]); end
            checks++; if (rv[k] !== 1'b0 || fl[k] !== 1'b0) begin errors++; $display("FAIL reset_fifo[%0d]: valid %b full %b want 0 0", k, rv[k], fl[k]); end
            checks++; if (cc[k] !== 16'd0 || oc[k] !== 16'd0) begin errors++; $display("FAIL reset_cnt[%0d]: commit %0d ovf %0d want 0 0", k, cc[k], oc[k]); end
            checks++; if (rdat[k] !== 32'd0 || rdst[k] !== 5'd0 || rs[k] !== 16'd0) begin errors++; $display("FAIL reset_rd[%0d]: data %h dest %0d stamp %0d want 0", k, rdat[k], rdst[k], rs[k]); end
        end
    endtask

    task automatic test_immediate();
        trig_en = 0;
        pulse_arm();
        checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL imm_armed: got %0d want 1", st0); end
        step();
        checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL imm_capture: got %0d want 2", st0); end
        do_write(5'd8, 32'h0000_0005);
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (rv[k] !== 1'b1 || rdst[k] !== 5'd8 || rdat[k] !== 32'd5) begin errors++; $display("FAIL imm_entry[%0d]: valid %b dest %0d data %h want 1 8 5", k, rv[k], rdst[k], rdat[k]); end
            checks++; if (cc[k] !== 16'd1) begin errors++; $display("FAIL imm_commit[%0d]: got %0d want 1", k, cc[k]); end
            checks++; if (rs[k] !== 16'(mq[k][0].stamp)) begin errors++; $display("FAIL imm_stamp[%0d]: got %0d want %0d", k, rs[k], mq[k][0].stamp); end
        end
        rd_ready = 1; step(); rd_ready = 0;
        pulse_stop();
        checks++; if (st0 !== 2'd3 || rv[0] !== 1'b0) begin errors++; $display("FAIL imm_done: state %0d valid %b want 3 0", st0, rv[0]); end
    endtask

    task automatic test_trigger();
        logic [1:0] seen [4];
        trig_en = 1; trig_pc = 32'h108; pc = 32'h0;
        pulse_arm();
        for (int unsigned i = 0; i < 3; i++) begin
            pc = 32'h100 + 32'(4 * i);
            seen[i] = st0;
            do_write(5'd4, 32'h11 + 32'(i));
        end
        seen[3] = st0;
        for (int unsigned i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== ((i == 3) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL trig_seq[%0d]: got %0d want %0d", i, seen[i], (i == 3) ? 2 : 1); end
        end
        checks++; if (rv[0] !== 1'b0 || cc0 !== 16'd0) begin errors++; $display("FAIL trig_nocap: valid %b commit %0d want 0 0", rv[0], cc0); end
        pc = 32'h10C;
        wwreg = 1; wm2reg = 1; wdest = 5'd9; wdo = 32'hDEAD_BEEF; wr = 32'h1;
        step(); wwreg = 0; wm2reg = 0;
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (rdat[k] !== 32'hDEAD_BEEF || rdst[k] !== 5'd9) begin errors++; $display("FAIL trig_data[%0d]: data %h dest %0d want deadbeef 9", k, rdat[k], rdst[k]); end
        end
    endtask

    task automatic test_skip_r0();
        // Drain the previous entry while writing r0.
        rd_ready = 1; wwreg = 1; wdest = 5'd0; wr = 32'h77;
        step(); rd_ready = 0; wwreg = 0;
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (rv[k] !== 1'b0 || cc[k] !== 16'd1) begin errors++; $display("FAIL skip_r0[%0d]: valid %b commit %0d want 0 1", k, rv[k], cc[k]); end
        end
        do_write(5'd3, 32'h33);
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (rv[k] !== 1'b1 || rdst[k] !== 5'd3 || rdat[k] !== 32'h33 || cc[k] !== 16'd2) begin errors++; $display("FAIL skip_r3[%0d]: valid %b dest %0d data %h commit %0d want 1 3 33 2", k, rv[k], rdst[k], rdat[k], cc[k]); end
        end
        rd_ready = 1; step(); rd_ready = 0;
        pulse_stop();
    endtask

    task automatic test_full_modes();
        trig_en = 0;
        pulse_arm(); step();
        for (int unsigned i = 1; i <= 6; i++) do_write(5'(i + 10), 32'(i));
        checks++; if (fl0 !== 1'b1 || st0 !== 2'd3 || oc0 !== 16'd1 || cc0 !== 16'd5) begin errors++; $display("FAIL stopfull: full %b state %0d ovf %0d commit %0d want 1 3 1 5", fl0, st0, oc0, cc0); end
        checks++; if (fl1 !== 1'b1 || st1 !== 2'd2 || oc1 !== 16'd2 || cc1 !== 16'd6) begin errors++; $display("FAIL wrapfull: full %b state %0d ovf %0d commit %0d want 1 2 2 6", fl1, st1, oc1, cc1); end
        for (int unsigned i = 0; i < 4; i++) begin
            checks++; if (rdat[0] !== 32'(i + 1) || rs[0] !== 16'(mq[0][0].stamp)) begin errors++; $display("FAIL stop_drain[%0d]: data %0d stamp %0d want %0d %0d", i, rdat[0], rs[0], i + 1, mq[0][0].stamp); end
            checks++; if (rdat[1] !== 32'(i + 3) || rs[1] !== 16'(mq[1][0].stamp)) begin errors++; $display("FAIL wrap_drain[%0d]: data %0d stamp %0d want %0d %0d", i, rdat[1], rs[1], i + 3, mq[1][0].stamp); end
            rd_ready = 1; step(); rd_ready = 0;
        end
        checks++; if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin errors++; $display("FAIL drained: valid %b %b want 0 0", rv[0], rv[1]); end
        for (int unsigned i = 7; i <= 10; i++) do_write(5'd5, 32'(i));
        checks++; if (fl1 !== 1'b1) begin errors++; $display("FAIL wrap_refill: full %b want 1", fl1); end
        rd_ready = 1; do_write(5'd5, 32'd11); rd_ready = 0;
        checks++; if (fl1 !== 1'b1 || oc1 !== 16'd2 || rdat[1] !== 32'd8) begin errors++; $display("FAIL wrap_poppush: full %b ovf %0d head %0d want 1 2 8", fl1, oc1, rdat[1]); end
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        trig_en = 0;
        pulse_arm(); step();
        for (int unsigned i = 0; i < 3; i++) do_write(5'd6, 32'hA0 + 32'(i));
        checks++; if (st0 !== 2'd2 || rv[0] !== 1'b1 || cc0 !== 16'd3) begin errors++; $display("FAIL mid_pre: state %0d valid %b commit %0d want 2 1 3", st0, rv[0], cc0); end
        rst = 1; wwreg = 1; wdest = 5'd6; step(); rst = 0; wwreg = 0;
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (st[k] !== 2'd0 || rv[k] !== 1'b0 || cc[k] !== 16'd0 || oc[k] !== 16'd0) begin errors++; $display("FAIL mid_rst[%0d]: state %0d valid %b commit %0d ovf %0d want 0 0 0 0", k, st[k], rv[k], cc[k], oc[k]); end
        end
    endtask

    task automatic test_arm_flush();
        trig_en = 0;
        pulse_arm(); step();
        do_write(5'd7, 32'h1); do_write(5'd7, 32'h2);
        pulse_stop();
        checks++; if (st0 !== 2'd3 || rv[0] !== 1'b1) begin errors++; $display("FAIL flush_pre: state %0d valid %b want 3 1", st0, rv[0]); end
        pulse_arm();
        for (int unsigned k = 0; k < 2; k++) begin
            checks++; if (st[k] !== 2'd1 || rv[k] !== 1'b0 || cc[k] !== 16'd0) begin errors++; $display("FAIL flush[%0d]: state %0d valid %b commit %0d want 1 0 0", k, st[k], rv[k], cc[k]); end
        end
        pulse_stop();
    endtask

    task automatic test_random();
        trig_pc = 32'h108;
        for (int unsigned c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            arm      = ($urandom_range(0, 14) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            trig_en  = $urandom_range(0, 1);
            pc       = 32'h100 + 32'(4 * $urandom_range(0, 3));
            wwreg    = ($urandom_range(0, 2) != 0);
            wm2reg   = $urandom_range(0, 1);
            wdest    = 5'($urandom_range(0, 4));
            wr       = $urandom;
            wdo      = $urandom;
            rd_ready = ($urandom_range(0, 3) == 0);
            step();
            for (int unsigned k = 0; k < 2; k++) begin
                checks++;
                if (st[k] !== 2'(m_state[k]) || fl[k] !== (mq[k].size() == MDEPTH) ||
                    cc[k] !== 16'(m_commit[k]) || oc[k] !== 16'(m_ovf[k]) ||
                    rv[k] !== (mq[k].size() != 0)) begin
                    errors++;
                    $display("FAIL rand_ctl[%0d] cyc %0d: state %0d full %b commit %0d ovf %0d valid %b want %0d %0d %0d %0d %0d",
                             k, c, st[k], fl[k], cc[k], oc[k], rv[k], m_state[k], mq[k].size() == MDEPTH,
                             m_commit[k], m_ovf[k], mq[k].size() != 0);
                end
                if (mq[k].size() != 0) begin
                    checks++;
                    if (rs[k] !== 16'(mq[k][0].stamp) || rdst[k] !== 5'(mq[k][0].dest) || rdat[k] !== mq[k][0].data) begin
                        errors++;
                        $display("FAIL rand_head[%0d] cyc %0d: stamp %0d dest %0d data %h want %0d %0d %h",
                                 k, c, rs[k], rdst[k], rdat[k], mq[k][0].stamp, mq[k][0].dest, mq[k][0].data);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_trigger();
        test_skip_r0();
        test_full_modes();
        test_reset_mid();
        test_arm_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
